// File: rtl/nand2_share_arb_pkg.sv
// Package for the NAND2 sharing arbiter.
// Contents: the FSM state type and the width helper used by the arbiter
// and its interface.
package nand2_share_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  // Index width that never collapses to zero bits, so a single-entry range
  // still gets a 1-bit field.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OP_CNT_W = 16;

endpackage

// File: rtl/nand2_share_arb_if.sv
// Requester-side bus of the NAND2 sharing arbiter.
//   req_valid/req_a/req_b : per-requester request and operands (master -> slave)
//   req_ready             : one-hot accept (slave -> master)
//   rsp_valid             : one-hot, one-cycle result strobe
//   rsp_y/rsp_err/rsp_id  : result, X/Z flag and index of the answered requester
//   busy/op_count         : arbiter status
interface nand2_share_arb_if
  import nand2_share_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_a;
  logic [NUM_REQ-1:0]      req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic                    rsp_y;
  logic                    rsp_err;
  logic [idw(NUM_REQ)-1:0] rsp_id;
  logic                    busy;
  logic [OP_CNT_W-1:0]     op_count;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_y, rsp_err, rsp_id, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_y, rsp_err, rsp_id, busy, op_count
  );

endinterface

// File: rtl/nand2_share_arb_nand2.sv
// Shared NAND2 cell.
//   A, B : operand inputs
//   Y    : NAND of A and B
// Kept as its own module so the arbiter only ever reaches it through the
// u_nand2 instance pins.
module NAND2 (
  input  logic A,
  input  logic B,
  output logic Y
);

  assign Y = ~(A & B);

endmodule

// File: rtl/nand2_share_arb.sv
// Round-robin arbiter and sequencer sharing one NAND2 cell among NUM_REQ
// requesters. One operand pair is accepted per grant, held on the cell for
// SETTLE_CYCLES cycles, then Y is sampled and returned to the requester.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : requester bus (slave side), see nand2_share_arb_if
module nand2_share_arb
  import nand2_share_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  nand2_share_arb_if.slave bus
);

  localparam int IDW   = idw(NUM_REQ);
  localparam int CNT_W = idw(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $fatal(1, "nand2_share_arb: SETTLE_CYCLES must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $fatal(1, "nand2_share_arb: NUM_REQ must be in 2..16");
  end

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      grant_id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                drive_a_q, drive_b_q;
  logic                cell_y;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                rsp_y_q, rsp_err_q;
  logic [IDW-1:0]      rsp_id_q;
  logic [OP_CNT_W-1:0] op_count_q;

  logic [IDW:0]        pick;
  logic                win_found;
  logic [IDW-1:0]      winner;
  logic [NUM_REQ-1:0]  ready;
  logic                accept;
  logic                sample;

  // Returns {found, index} of the first valid requester scanning upward from
  // ptr with wrap. Scanning offsets high-to-low lets the lowest offset win.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (v[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  assign pick      = rr_pick(bus.req_valid, rr_ptr_q);
  assign win_found = pick[IDW];
  assign winner    = pick[IDW-1:0];

  // The cell sees only the frozen drive registers, never the request ports.
  NAND2 u_nand2 (
    .A (drive_a_q),
    .B (drive_b_q),
    .Y (cell_y)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ready   = '0;
    accept  = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          ready[winner] = 1'b1;
          accept        = 1'b1;
          state_d       = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      cnt_q       <= '0;
      drive_a_q   <= 1'b0;
      drive_b_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_y_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;

      if (accept) begin
        drive_a_q  <= bus.req_a[winner];
        drive_b_q  <= bus.req_b[winner];
        grant_id_q <= winner;
        rr_ptr_q   <= IDW'((int'(winner) + 1) % NUM_REQ);
        cnt_q      <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (state_q == SETTLE && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (sample) begin
        rsp_valid_q[grant_id_q] <= 1'b1;
        rsp_id_q                <= grant_id_q;
        op_count_q              <= op_count_q + 1'b1;
        // A floating or contended cell output is reported, not passed on.
        if ($isunknown(cell_y)) begin
          rsp_y_q   <= 1'b0;
          rsp_err_q <= 1'b1;
        end else begin
          rsp_y_q   <= cell_y;
          rsp_err_q <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;

endmodule
